// File: rtl/test_harness_ctrl.sv
// Test harness controller: sequences per-test resets for NUM_TESTS test
// instances (parallel or one-at-a-time), watches a RUN-phase watchdog and
// aggregates a sticky fail vector plus an overall pass/done verdict.
module test_harness_ctrl #(
  parameter int unsigned NUM_TESTS   = 4,
  parameter int unsigned SEQUENTIAL  = 0,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT     = 1000,
  localparam int unsigned IDX_W      = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [NUM_TESTS-1:0] test_fail_i,
  input  logic [NUM_TESTS-1:0] test_finish_i,
  output logic [NUM_TESTS-1:0] test_reset_o,
  output logic [IDX_W-1:0]     cur_test_o,
  output logic [NUM_TESTS-1:0] fail_vec_o,
  output logic                 timeout_o,
  output logic                 done_o,
  output logic                 pass_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [NUM_TESTS-1:0]   test_reset_q;
  logic [IDX_W-1:0]       cur_test_q;
  logic [NUM_TESTS-1:0]   fail_vec_q;
  logic [NUM_TESTS-1:0]   fin_q;
  logic                   timeout_q;
  logic                   done_q;
  logic                   pass_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [TIMEOUT_W-1:0]   wd_q;

  logic [NUM_TESTS-1:0]   run_fail;
  logic [NUM_TESTS-1:0]   run_fin;
  logic [NUM_TESTS-1:0]   fin_d;
  logic [NUM_TESTS-1:0]   fail_vec_d;
  logic [NUM_TESTS-1:0]   seq_mask;
  logic                   complete;
  logic                   wd_expire;
  logic                   seq_last;
  logic                   hold_last;

  // Result qualification: only released tests (test_reset low) are observed
  always_comb begin
    run_fail   = test_fail_i & ~test_reset_q;
    run_fin    = test_finish_i & ~test_reset_q;
    fin_d      = fin_q | run_fin;
    fail_vec_d = fail_vec_q | run_fail;
    complete   = 1'b0;
    if (SEQUENTIAL != 0) begin
      complete = (|run_fail) | (|run_fin);
    end else begin
      complete = (|run_fail) | (&fin_d);
    end
    wd_expire = (TIMEOUT != 0) && (wd_q == TIMEOUT_W'(TIMEOUT - 1));
    seq_mask  = ~(NUM_TESTS'(1) << cur_test_q);
    seq_last  = (cur_test_q == IDX_W'(NUM_TESTS - 1));
    hold_last = (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      test_reset_q <= '1;
      cur_test_q   <= '0;
      fail_vec_q   <= '0;
      fin_q        <= '0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      hold_cnt_q   <= '0;
      wd_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          test_reset_q <= '1;
          if (start_i) begin
            state_q    <= S_HOLD;
            fail_vec_q <= '0;
            fin_q      <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            cur_test_q <= '0;
            hold_cnt_q <= '0;
          end
        end
        S_HOLD: begin
          if (hold_last) begin
            state_q      <= S_RUN;
            hold_cnt_q   <= '0;
            wd_q         <= '0;
            test_reset_q <= (SEQUENTIAL != 0) ? seq_mask : '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          fail_vec_q <= fail_vec_d;
          fin_q      <= fin_d;
          wd_q       <= wd_q + 1'b1;
          if (complete) begin
            test_reset_q <= '1;
            if ((SEQUENTIAL != 0) && !(|run_fail) && !seq_last) begin
              // Next test gets a fresh reset hold before release
              state_q    <= S_HOLD;
              cur_test_q <= cur_test_q + 1'b1;
              hold_cnt_q <= '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= ~(|fail_vec_d);
            end
          end else if (wd_expire) begin
            state_q      <= S_DONE;
            test_reset_q <= '1;
            timeout_q    <= 1'b1;
            done_q       <= 1'b1;
            pass_q       <= 1'b0;
          end
        end
        S_DONE: begin
          test_reset_q <= '1;
          if (!start_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign test_reset_o = test_reset_q;
  assign cur_test_o   = cur_test_q;
  assign fail_vec_o   = fail_vec_q;
  assign timeout_o    = timeout_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Directed bench for test_harness_ctrl: parallel, sequential and short-timeout
// instances sharing one clock and reset.
module tb_test_harness_ctrl;

  logic clk;
  logic rst_n;

  // Parallel instance, N=4
  logic       start_p;
  logic [3:0] fail_p, fin_p, tr_p, fv_p;
  logic [1:0] cur_p;
  logic       to_p, done_p, pass_p;

  // Sequential instance, N=3
  logic       start_s;
  logic [2:0] fail_s, fin_s, tr_s, fv_s;
  logic [1:0] cur_s;
  logic       to_s, done_s, pass_s;

  // Parallel instance with short watchdog, N=2
  logic       start_t;
  logic [1:0] fail_t, fin_t, tr_t, fv_t;
  logic [0:0] cur_t;
  logic       to_t, done_t, pass_t;

  int n_checks;
  int n_pass;
  int n;
  logic rel2;

  test_harness_ctrl #(.NUM_TESTS(4), .SEQUENTIAL(0), .HOLD_CYCLES(16),
                      .TIMEOUT_W(16), .TIMEOUT(1000)) u_par (
    .clk(clk), .rst_n(rst_n), .start_i(start_p),
    .test_fail_i(fail_p), .test_finish_i(fin_p), .test_reset_o(tr_p),
    .cur_test_o(cur_p), .fail_vec_o(fv_p), .timeout_o(to_p),
    .done_o(done_p), .pass_o(pass_p));

  test_harness_ctrl #(.NUM_TESTS(3), .SEQUENTIAL(1), .HOLD_CYCLES(16),
                      .TIMEOUT_W(16), .TIMEOUT(1000)) u_seq (
    .clk(clk), .rst_n(rst_n), .start_i(start_s),
    .test_fail_i(fail_s), .test_finish_i(fin_s), .test_reset_o(tr_s),
    .cur_test_o(cur_s), .fail_vec_o(fv_s), .timeout_o(to_s),
    .done_o(done_s), .pass_o(pass_s));

  test_harness_ctrl #(.NUM_TESTS(2), .SEQUENTIAL(0), .HOLD_CYCLES(16),
                      .TIMEOUT_W(16), .TIMEOUT(50)) u_to (
    .clk(clk), .rst_n(rst_n), .start_i(start_t),
    .test_fail_i(fail_t), .test_finish_i(fin_t), .test_reset_o(tr_t),
    .cur_test_o(cur_t), .fail_vec_o(fv_t), .timeout_o(to_t),
    .done_o(done_t), .pass_o(pass_t));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison; report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [3:0] get_tr(input int sel);
    case (sel)
      0:       return tr_p;
      1:       return {1'b1, tr_s};
      default: return {2'b11, tr_t};
    endcase
  endfunction

  // Wait (bounded) for a test_reset pattern; n = falling edges waited
  task automatic wait_tr(input int sel, input logic [3:0] pat, output int cnt);
    cnt = 0;
    while (get_tr(sel) !== pat && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    if (get_tr(sel) !== pat) check("wait_tr", 32'(get_tr(sel)), 32'(pat));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    start_p = 0; fail_p = '0; fin_p = '0;
    start_s = 0; fail_s = '0; fin_s = '0;
    start_t = 0; fail_t = '0; fin_t = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_tr",   32'(tr_p), 32'hf);
    check("rst_cur",  32'(cur_p), 32'h0);
    check("rst_fv",   32'(fv_p), 32'h0);
    check("rst_to",   32'(to_p), 32'h0);
    check("rst_done", 32'(done_p), 32'h0);
    check("rst_pass", 32'(pass_p), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Parallel, all finish at cycles 5,9,14,20
    start_p = 1'b1;
    wait_tr(0, 4'h0, n);
    check("par_hold_len", 32'(n), 32'd17);
    for (int c = 1; c <= 20; c++) begin
      fin_p = {c == 20, c == 14, c == 9, c == 5};
      @(negedge clk);
      if (c == 19) check("par_not_done_c19", 32'(done_p), 32'h0);
    end
    fin_p = '0;
    check("par_done", 32'(done_p), 32'h1);
    check("par_pass", 32'(pass_p), 32'h1);
    check("par_fv",   32'(fv_p), 32'h0);
    check("par_tr",   32'(tr_p), 32'hf);
    repeat (3) @(negedge clk);
    check("par_done_held", 32'(done_p), 32'h1);
    start_p = 1'b0;
    @(negedge clk);
    check("par_done_drop", 32'(done_p), 32'h0);
    check("par_pass_hold", 32'(pass_p), 32'h1);

    // Parallel, test 2 fails at RUN cycle 7; start dropped mid-run
    start_p = 1'b1;
    wait_tr(0, 4'h0, n);
    start_p = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      fin_p  = (c == 3) ? 4'b0001 : 4'b0000;
      fail_p = (c == 7) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (c == 6) check("pf_not_done_c6", 32'(done_p), 32'h0);
    end
    fin_p = '0; fail_p = '0;
    check("pf_done", 32'(done_p), 32'h1);
    check("pf_fv",   32'(fv_p), 32'h4);
    check("pf_pass", 32'(pass_p), 32'h0);
    check("pf_tr",   32'(tr_p), 32'hf);
    @(negedge clk);
    check("pf_idle_done", 32'(done_p), 32'h0);
    check("pf_fv_hold",   32'(fv_p), 32'h4);

    // Sequential, all pass; fail on unreleased test 2 is ignored
    start_s = 1'b1;
    wait_tr(1, 4'b1110, n);
    check("seq_hold_len", 32'(n), 32'd17);
    check("seq_cur0", 32'(cur_s), 32'h0);
    fail_s = 3'b100;
    repeat (3) @(negedge clk);
    fail_s = '0;
    fin_s = 3'b001;
    @(negedge clk);
    fin_s = '0;
    check("seq_rereset", 32'(tr_s), 32'h7);
    check("seq_cur1",    32'(cur_s), 32'h1);
    check("seq_mid_done", 32'(done_s), 32'h0);
    wait_tr(1, 4'b1101, n);
    check("seq_gap_len", 32'(n), 32'd16);
    check("seq_fv_ign",  32'(fv_s), 32'h0);
    @(negedge clk);
    fin_s = 3'b010;
    @(negedge clk);
    fin_s = '0;
    wait_tr(1, 4'b1011, n);
    check("seq_cur2", 32'(cur_s), 32'h2);
    fin_s = 3'b100;
    @(negedge clk);
    fin_s = '0;
    check("seq_done",    32'(done_s), 32'h1);
    check("seq_pass",    32'(pass_s), 32'h1);
    check("seq_cur_end", 32'(cur_s), 32'h2);
    check("seq_tr_end",  32'(tr_s), 32'h7);
    start_s = 1'b0;
    @(negedge clk);

    // Sequential, test 1 fail+finish together
    start_s = 1'b1;
    wait_tr(1, 4'b1110, n);
    fin_s = 3'b001;
    @(negedge clk);
    fin_s = '0;
    wait_tr(1, 4'b1101, n);
    fail_s = 3'b010; fin_s = 3'b010;
    @(negedge clk);
    fail_s = '0; fin_s = '0;
    check("sf_done", 32'(done_s), 32'h1);
    check("sf_fv",   32'(fv_s), 32'h2);
    check("sf_pass", 32'(pass_s), 32'h0);
    check("sf_cur",  32'(cur_s), 32'h1);
    rel2 = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tr_s[2] !== 1'b1) rel2 = 1'b1;
    end
    check("sf_t2_never", 32'(rel2), 32'h0);
    check("sf_done_held", 32'(done_s), 32'h1);
    start_s = 1'b0;
    @(negedge clk);

    // Watchdog: no finish -> timeout at RUN cycle 50
    start_t = 1'b1;
    wait_tr(2, 4'b1100, n);
    start_t = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 49) begin
        check("to_not_done_c49", 32'(done_t), 32'h0);
        check("to_flag_c49",     32'(to_t), 32'h0);
      end
    end
    check("to_flag", 32'(to_t), 32'h1);
    check("to_done", 32'(done_t), 32'h1);
    check("to_pass", 32'(pass_t), 32'h0);
    @(negedge clk);

    // Watchdog: completion on cycle 50 wins
    start_t = 1'b1;
    wait_tr(2, 4'b1100, n);
    start_t = 1'b0;
    check("to2_cleared", 32'(to_t), 32'h0);
    for (int c = 1; c <= 50; c++) begin
      fin_t = (c == 10) ? 2'b01 : ((c == 50) ? 2'b10 : 2'b00);
      @(negedge clk);
    end
    fin_t = '0;
    check("to2_done", 32'(done_t), 32'h1);
    check("to2_flag", 32'(to_t), 32'h0);
    check("to2_pass", 32'(pass_t), 32'h1);
    @(negedge clk);

    // Asynchronous reset mid-RUN of test 1, then a clean relaunch
    start_s = 1'b1;
    wait_tr(1, 4'b1110, n);
    fin_s = 3'b001;
    @(negedge clk);
    fin_s = '0;
    wait_tr(1, 4'b1101, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cur",  32'(cur_s), 32'h0);
    check("ar_tr",   32'(tr_s), 32'h7);
    check("ar_done", 32'(done_s), 32'h0);
    check("ar_fv",   32'(fv_s), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tr(1, 4'b1110, n);
    check("ar_relaunch_len", 32'(n), 32'd17);
    fin_s = 3'b001;
    @(negedge clk);
    fin_s = '0;
    wait_tr(1, 4'b1101, n);
    fin_s = 3'b010;
    @(negedge clk);
    fin_s = '0;
    wait_tr(1, 4'b1011, n);
    fin_s = 3'b100;
    @(negedge clk);
    fin_s = '0;
    check("ar_done_end", 32'(done_s), 32'h1);
    check("ar_pass_end", 32'(pass_s), 32'h1);
    check("ar_cur_end",  32'(cur_s), 32'h2);
    start_s = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
